yolo_maxpool: RTL and testbench

YOLO_MAXPOOL -- requirements
Module: yolo_maxpool

---
 rtl/yolo_maxpool_if.sv | 23 ++
 rtl/yolo_maxpool.sv | 113 +++++++++++
 tb/tb_yolo_maxpool.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/yolo_maxpool_if.sv
// Pixel stream and frame-control bundle for the 2x2 max-pool block.
// slave = pooling core side, master = upstream producer / downstream consumer side.
interface yolo_maxpool_if #(
  parameter int BITWIDTH = 8
);
  logic                pool_en;
  logic                in_valid;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic [BITWIDTH-1:0] out_data;
  logic                pool_busy;
  logic                pool_fin;

  modport slave (
    input  pool_en, in_valid, in_data,
    output out_valid, out_data, pool_busy, pool_fin
  );

  modport master (
    output pool_en, in_valid, in_data,
    input  out_valid, out_data, pool_busy, pool_fin
  );
endinterface

// File: rtl/yolo_maxpool.sv
// Streaming 2x2 / stride-2 signed max pooling over a raster-order feature map.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows close each window.
module yolo_maxpool #(
  parameter int BITWIDTH   = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic            clk_en,
  input  logic            rst_n,
  yolo_maxpool_if.slave   pool_if
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_N  = IMG_WIDTH / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                     state_reg, state_next;
  logic [COL_W-1:0]           col_reg;
  logic [ROW_W-1:0]           row_reg;
  logic signed [BITWIDTH-1:0] pair_reg;
  logic signed [BITWIDTH-1:0] lb_rd_reg;
  logic signed [BITWIDTH-1:0] out_data_reg;
  logic                       out_valid_reg;
  logic signed [BITWIDTH-1:0] line_buf [LB_N];

  logic                       accept;
  logic                       last_col;
  logic                       last_row;
  logic [LB_AW-1:0]           lb_addr;
  logic signed [BITWIDTH-1:0] pair_max;
  logic signed [BITWIDTH-1:0] win_max;

  function automatic logic signed [BITWIDTH-1:0] smax(
    input logic signed [BITWIDTH-1:0] a,
    input logic signed [BITWIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign accept   = (state_reg == RUN) && pool_if.in_valid;
  assign last_col = (col_reg == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_reg == ROW_W'(IMG_HEIGHT - 1));
  assign lb_addr  = LB_AW'(col_reg >> 1);
  assign pair_max = smax(pair_reg, pool_if.in_data);
  assign win_max  = smax(pair_max, lb_rd_reg);

  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pool_if.pool_en) state_next = RUN;
      RUN:     if (accept && last_col && last_row) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      pair_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      if (state_reg == IDLE && pool_if.pool_en) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_reg <= '0;
          row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
        if (!col_reg[0]) begin
          pair_reg <= pool_if.in_data;
        end else if (row_reg[0]) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= win_max;
        end
      end
    end
  end

  // Line buffer has no reset: each entry is written on an even row before the odd row reads it.
  // The read is registered on the even column so the value is ready when the window closes.
  always_ff @(posedge clk_en) begin
    if (accept && col_reg[0] && !row_reg[0]) begin
      line_buf[lb_addr] <= pair_max;
    end
    if (accept && !col_reg[0] && row_reg[0]) begin
      lb_rd_reg <= line_buf[lb_addr];
    end
  end

  assign pool_if.out_valid = out_valid_reg;
  assign pool_if.out_data  = out_data_reg;
  assign pool_if.pool_busy = (state_reg != IDLE);
  assign pool_if.pool_fin  = (state_reg == FIN);

endmodule

// File: tb/tb_yolo_maxpool.sv
// Bench for yolo_maxpool on a 4x4 map: fixed vector table, random frames vs a window-max model,
// plus hand sequences for mid-frame reset, pool_en held through RUN/FIN and in_valid while idle.
module tb_yolo_maxpool;

  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk_en;
  logic rst_n;

  yolo_maxpool_if #(.BITWIDTH(BW)) pif ();

  yolo_maxpool #(
    .BITWIDTH   (BW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_en  (clk_en),
    .rst_n   (rst_n),
    .pool_if (pif)
  );

  initial clk_en = 1'b0;
  always #5 clk_en = ~clk_en;

  typedef struct packed {
    logic [15:0][7:0] pix;
    logic [3:0][7:0]  exp;
    logic [1:0]       gap;
  } vec_t;

  vec_t vecs [4];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hold_v = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input bit ev, input bit ef, input bit eb);
    chk({nm, " out_valid"}, int'(pif.out_valid), int'(ev));
    chk({nm, " out_data"},  int'($signed(pif.out_data)), hold_v);
    chk({nm, " pool_fin"},  int'(pif.pool_fin), int'(ef));
    chk({nm, " pool_busy"}, int'(pif.pool_busy), int'(eb));
  endtask

  // Reference: plain 2x2 window maxima of a 4x4 raster frame, signed.
  function automatic logic [3:0][7:0] ref_pool(input logic [15:0][7:0] p);
    logic [3:0][7:0] r;
    r = '0;
    for (int wr = 0; wr < 2; wr++) begin
      for (int wc = 0; wc < 2; wc++) begin
        int m;
        m = -1000;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            int v;
            v = int'($signed(p[(2*wr+dr)*W + 2*wc + dc]));
            if (v > m) m = v;
          end
        end
        r[wr*2+wc] = 8'(m);
      end
    end
    return r;
  endfunction

  // Runs one frame from IDLE; called and returns just after a falling edge.
  // gap: 0 continuous, 1 bubble every other cycle, 2 random bubbles.
  task automatic run_frame(input logic [15:0][7:0] pix, input logic [3:0][7:0] exp,
                           input int gap, input bit hold_en, input string nm);
    int  idx;
    int  cyc;
    bit  v;
    bit  ev;
    int  r;
    int  c;
    pif.pool_en  = 1'b1;
    pif.in_valid = 1'b0;
    @(negedge clk_en);
    chk({nm, " start busy"}, int'(pif.pool_busy), 1);
    if (!hold_en) pif.pool_en = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      if (gap == 1)      v = cyc[0];
      else if (gap == 2) v = ($urandom_range(0, 2) != 0);
      else               v = 1'b1;
      pif.in_valid = v;
      pif.in_data  = v ? pix[idx] : 8'($urandom);
      @(negedge clk_en);
      r  = idx / W;
      c  = idx % W;
      ev = v && (r % 2 == 1) && (c % 2 == 1);
      if (ev) hold_v = int'($signed(exp[(r/2)*2 + c/2]));
      check_out($sformatf("%s px%0d", nm, idx), ev, v && idx == 15, 1'b1);
      if (v) idx++;
      cyc++;
    end
    if (idx < 16) chk({nm, " frame timeout"}, idx, 16);
    pif.in_valid = 1'b0;
    @(negedge clk_en);
    check_out({nm, " after fin"}, 1'b0, 1'b0, 1'b0);
    pif.pool_en = 1'b0;
  endtask

  initial begin
    int neg [16];
    int mix [16];
    logic [15:0][7:0] rp;

    rst_n        = 1'b0;
    pif.pool_en  = 1'b0;
    pif.in_valid = 1'b0;
    pif.in_data  = '0;
    #12;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk_en);
    rst_n = 1'b1;
    @(negedge clk_en);
    check_out("idle", 1'b0, 1'b0, 1'b0);

    neg = '{-8, -3, -5, -1, -2, -7, -4, -6, -10, -20, -30, -40, -50, -60, -70, -128};
    mix = '{127, -128, 0, 1, -1, 5, -5, 3, 100, -100, 2, 2, -3, 99, 2, 2};
    for (int i = 0; i < 16; i++) begin
      vecs[0].pix[i] = 8'(i);
      vecs[1].pix[i] = 8'(neg[i]);
      vecs[2].pix[i] = 8'(i);
      vecs[3].pix[i] = 8'(mix[i]);
    end
    vecs[0].exp = {8'd15, 8'd13, 8'd7, 8'd5};
    vecs[0].gap = 2'd0;
    vecs[1].exp[0] = 8'(-2);
    vecs[1].exp[1] = 8'(-1);
    vecs[1].exp[2] = 8'(-10);
    vecs[1].exp[3] = 8'(-30);
    vecs[1].gap = 2'd0;
    vecs[2].exp = {8'd15, 8'd13, 8'd7, 8'd5};
    vecs[2].gap = 2'd1;
    vecs[3].exp = {8'd2, 8'd100, 8'd3, 8'd127};
    vecs[3].gap = 2'd2;

    for (int t = 0; t < 4; t++) begin
      run_frame(vecs[t].pix, vecs[t].exp, int'(vecs[t].gap), 1'b0, $sformatf("vec%0d", t));
      $display("vector %0d done: compared=%0d mismatched=%0d", t, n_cmp, n_bad);
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) rp[i] = 8'($urandom);
      run_frame(rp, ref_pool(rp), 2, 1'b0, $sformatf("rand%0d", t));
      $display("random frame %0d done: compared=%0d mismatched=%0d", t, n_cmp, n_bad);
    end

    // pool_en held through RUN and the FIN cycle: one frame, one pool_fin.
    run_frame(vecs[0].pix, vecs[0].exp, 0, 1'b1, "hold_en");
    $display("pool_en hold frame done: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Reset after pixel 9 of a ramp frame.
    pif.pool_en = 1'b1;
    @(negedge clk_en);
    pif.pool_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pif.in_valid = 1'b1;
      pif.in_data  = 8'(i);
      @(negedge clk_en);
      if (i == 5 || i == 7) hold_v = i;
      check_out($sformatf("pre_rst px%0d", i), (i == 5 || i == 7), 1'b0, 1'b1);
    end
    pif.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    hold_v = 0;
    check_out("async rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk_en);
    pif.in_valid = 1'b1;
    pif.in_data  = 8'($urandom);
    @(negedge clk_en);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pif.in_data = 8'($urandom);
      @(negedge clk_en);
      check_out($sformatf("post_rst c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    pif.in_valid = 1'b0;
    run_frame(vecs[0].pix, vecs[0].exp, 0, 1'b0, "after_rst");
    $display("reset sequence done: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // in_valid while idle must not disturb counters or outputs.
    for (int i = 0; i < 7; i++) begin
      pif.in_valid = 1'b1;
      pif.in_data  = 8'($urandom);
      @(negedge clk_en);
      check_out($sformatf("idle_in c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    pif.in_valid = 1'b0;
    run_frame(vecs[3].pix, vecs[3].exp, 0, 1'b0, "after_idle");
    $display("idle in_valid sequence done: compared=%0d mismatched=%0d", n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
